// File: rtl/vram_display_arbiter.sv
// vram_display_arbiter: owns the single-port video RAM, shares it between the
// VGA line fetch (fixed priority) and the CPU bus, serialises 1 bpp bytes into
// pixel_r/g/b and holds the colour/control registers.
// Optional build macro VRAM_CLEAR_EN adds a post-reset VRAM clear sequencer.
module vram_display_arbiter #(
  parameter int          H_BYTES  = 80,
  parameter int          V_LINES  = 400,
  parameter int          VRAM_AW  = 15,
  parameter logic [15:0] CFG_BASE = 16'hFF00
) (
  input  logic               clk_25m,
  input  logic               rst,
  input  logic [11:0]        row,
  input  logic [11:0]        colum,
  input  logic               pix_valid,
  output logic               pixel_r,
  output logic               pixel_g,
  output logic               pixel_b,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_ack
);

  localparam int VRAM_BYTES = H_BYTES * V_LINES;

  // Line base address: row*80 built from two shifts, truncated to the RAM width.
  function automatic logic [VRAM_AW-1:0] line_base(input logic [11:0] r);
    logic [VRAM_AW-1:0] rw;
    rw = VRAM_AW'(r);
    return (rw << 6) + (rw << 4);
  endfunction

  logic               pv_d_r, pf_slot_r, pf_load_r, inline_d_r;
  logic [11:0]        pf_row_r, pf_next_row_s;
  logic [7:0]         cur_byte_r, nxt_byte_r;
  logic [2:0]         fg_r, bg_r, colour_s, pix_s;
  logic               enable_r, invert_r, bit_s;
  logic               done_r, ack_r, ack_vram_rd_r;
  logic [7:0]         rdata_r, reg_rdata_s;
  logic               fall_s, inline_s, disp_s;
  logic               is_vram_s, is_col_s, is_ctl_s, new_req_s, cpu_go_s, cpu_reg_s;
  logic               busy_s, clr_go_s;
  logic [VRAM_AW-1:0] clr_addr_s;

  // A falling edge of pix_valid on a displayed row schedules the next-line prefetch.
  assign fall_s    = pv_d_r & ~pix_valid & (row < 12'(V_LINES));
  // The last byte of a line has no successor, so no in-line fetch there.
  assign inline_s  = pix_valid & (colum[2:0] == 3'd1) & (colum[11:3] < 9'(H_BYTES - 1));
  assign disp_s    = pf_slot_r | inline_s;
  assign pf_next_row_s = (pf_row_r == 12'(V_LINES - 1)) ? 12'd0 : pf_row_r + 12'd1;

  assign is_vram_s = cpu_addr < 16'(VRAM_BYTES);
  assign is_col_s  = cpu_addr == CFG_BASE;
  assign is_ctl_s  = cpu_addr == (CFG_BASE + 16'd1);
  // A new request is only taken once req has been seen low after the previous ack.
  assign new_req_s = cpu_req & ~done_r & ~rst;
  assign cpu_go_s  = new_req_s & is_vram_s & ~disp_s & ~busy_s;
  assign cpu_reg_s = new_req_s & ~is_vram_s;
  assign clr_go_s  = busy_s & ~disp_s & ~rst;

`ifdef VRAM_CLEAR_EN
  localparam logic [VRAM_AW-1:0] LAST_ADDR = VRAM_AW'(VRAM_BYTES - 1);
  logic               clr_active_r;
  logic [VRAM_AW-1:0] clr_addr_r;

  // Walk the displayed region once after reset, advancing only on cycles the clear owns the RAM.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      clr_active_r <= 1'b1;
      clr_addr_r   <= '0;
    end else if (clr_go_s) begin
      clr_addr_r   <= clr_addr_r + VRAM_AW'(1);
      clr_active_r <= (clr_addr_r != LAST_ADDR);
    end else begin
      clr_active_r <= clr_active_r;
      clr_addr_r   <= clr_addr_r;
    end
  end

  assign busy_s     = clr_active_r;
  assign clr_addr_s = clr_addr_r;
`else
  assign busy_s     = 1'b0;
  assign clr_addr_s = '0;
`endif

  // RAM port mux: prefetch, in-line fetch, clear, then CPU; idle drives zeros.
  always_comb begin
    vram_addr  = '0;
    vram_we    = 1'b0;
    vram_wdata = 8'h00;
    if (rst) begin
      vram_addr = '0;
    end else if (pf_slot_r) begin
      vram_addr = line_base(pf_next_row_s);
    end else if (inline_s) begin
      vram_addr = line_base(row) + VRAM_AW'(colum[11:3]) + VRAM_AW'(1);
    end else if (clr_go_s) begin
      vram_addr  = clr_addr_s;
      vram_we    = 1'b1;
      vram_wdata = 8'h00;
    end else if (cpu_go_s) begin
      vram_addr  = cpu_addr[VRAM_AW-1:0];
      vram_we    = cpu_we;
      vram_wdata = cpu_we ? cpu_wdata : 8'h00;
    end else begin
      vram_addr = '0;
    end
  end

  // Register-file read view; unmapped addresses read as zero.
  always_comb begin
    reg_rdata_s = 8'h00;
    if (is_col_s) begin
      reg_rdata_s = {1'b0, bg_r, 1'b0, fg_r};
    end else if (is_ctl_s) begin
      reg_rdata_s = {busy_s, 5'b00000, invert_r, enable_r};
    end else begin
      reg_rdata_s = 8'h00;
    end
  end

  // Display pipeline: edge detect, prefetch scheduling and the two byte buffers.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      pv_d_r     <= 1'b0;
      pf_slot_r  <= 1'b0;
      pf_load_r  <= 1'b0;
      inline_d_r <= 1'b0;
      pf_row_r   <= 12'd0;
      cur_byte_r <= 8'h00;
      nxt_byte_r <= 8'h00;
    end else begin
      pv_d_r     <= pix_valid;
      pf_slot_r  <= fall_s;
      pf_load_r  <= pf_slot_r;
      inline_d_r <= inline_s & ~pf_slot_r;
      if (fall_s) pf_row_r <= row;
      else        pf_row_r <= pf_row_r;
      if (pf_load_r)                             cur_byte_r <= vram_rdata;
      else if (pix_valid && colum[2:0] == 3'd7)  cur_byte_r <= nxt_byte_r;
      else                                       cur_byte_r <= cur_byte_r;
      if (inline_d_r) nxt_byte_r <= vram_rdata;
      else            nxt_byte_r <= nxt_byte_r;
    end
  end

  // CPU handshake, register writes and the one-cycle ack with its read data.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      done_r        <= 1'b0;
      ack_r         <= 1'b0;
      ack_vram_rd_r <= 1'b0;
      rdata_r       <= 8'h00;
      fg_r          <= 3'b111;
      bg_r          <= 3'b000;
      enable_r      <= 1'b1;
      invert_r      <= 1'b0;
    end else begin
      ack_r         <= cpu_go_s | cpu_reg_s;
      ack_vram_rd_r <= cpu_go_s & ~cpu_we;
      rdata_r       <= (cpu_reg_s & ~cpu_we) ? reg_rdata_s : 8'h00;
      if (cpu_go_s || cpu_reg_s) done_r <= 1'b1;
      else if (!cpu_req)         done_r <= 1'b0;
      else                       done_r <= done_r;
      if (cpu_reg_s && cpu_we && is_col_s) begin
        fg_r <= cpu_wdata[2:0];
        bg_r <= cpu_wdata[6:4];
      end else begin
        fg_r <= fg_r;
        bg_r <= bg_r;
      end
      if (cpu_reg_s && cpu_we && is_ctl_s) begin
        enable_r <= cpu_wdata[0];
        invert_r <= cpu_wdata[1];
      end else begin
        enable_r <= enable_r;
        invert_r <= invert_r;
      end
    end
  end

  // VRAM read data is forwarded straight from the RAM during its ack cycle.
  assign cpu_rdata = ack_vram_rd_r ? vram_rdata : rdata_r;
  assign cpu_ack   = ack_r;

  // Pixel colour for the current column, zero latency from colum.
  always_comb begin
    bit_s    = cur_byte_r[3'd7 - colum[2:0]];
    colour_s = (bit_s ^ invert_r) ? fg_r : bg_r;
    if (enable_r && !rst) pix_s = colour_s;
    else                  pix_s = 3'b000;
  end

  assign {pixel_r, pixel_g, pixel_b} = pix_s;

endmodule

// File: tb/tb_vram_display_arbiter.sv
// Directed self-checking bench for vram_display_arbiter with a behavioural
// synchronous-read VRAM model.
module tb_vram_display_arbiter;

  logic        clk_25m, rst, pix_valid;
  logic [11:0] row, colum;
  logic        pixel_r, pixel_g, pixel_b;
  logic [14:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata, vram_rdata;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem [0:32767];
  int          we_cnt = 0;
  logic [14:0] last_wa = '0;
  logic [7:0]  last_wd = 8'h00;
  logic [7:0]  rd;
  int          cyc;
  int          n0;

  vram_display_arbiter dut (
    .clk_25m(clk_25m), .rst(rst), .row(row), .colum(colum), .pix_valid(pix_valid),
    .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack)
  );

  initial clk_25m = 1'b0;
  always #20 clk_25m = ~clk_25m;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
  end

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk_25m) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  // Write monitor, sampled mid-cycle.
  always @(negedge clk_25m) begin
    if (vram_we) begin
      we_cnt  <= we_cnt + 1;
      last_wa <= vram_addr;
      last_wd <= vram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU transaction; returns read data and cycles to ack; checks ack is a single pulse.
  task automatic cpu_txn(input string tag, input logic we, input logic [15:0] a, input logic [7:0] d,
                         input int limit, input int hold, output logic [7:0] rdo, output int cy);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cy = 0;
    do begin
      @(posedge clk_25m); #1; cy++;
    end while (cpu_ack !== 1'b1 && cy < limit);
    rdo = cpu_rdata;
    check({tag, "_ack"}, cpu_ack, 1);
    for (int i = 0; i <= hold; i++) begin
      @(posedge clk_25m); #1;
      check({tag, "_noack"}, cpu_ack, 0);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(posedge clk_25m); #1;
  endtask

  // Drive one displayed line, optionally checking pixels against bytes 0x80,0x01, then check the prefetch.
  task automatic run_line(input logic [11:0] r, input int ncols, input logic chk, input logic [14:0] pf_exp,
                          input logic [2:0] fg, input logic [2:0] bg, input logic en, input logic inv);
    logic [15:0] pat;
    logic        b;
    logic [2:0]  ex;
    pat = 16'h8001;
    for (int c = 0; c < ncols; c++) begin
      row = r; colum = 12'(c); pix_valid = 1'b1;
      #1;
      if (chk) begin
        b  = (c < 16) ? pat[15 - c] : 1'b0;
        ex = en ? ((b ^ inv) ? fg : bg) : 3'b000;
        check($sformatf("pix_r%0d_c%0d", r, c), {pixel_r, pixel_g, pixel_b}, ex);
      end
      @(posedge clk_25m); #1;
    end
    pix_valid = 1'b0; colum = 12'(ncols);
    @(posedge clk_25m); #2;
    check($sformatf("pf_addr_r%0d", r), vram_addr, pf_exp);
    check($sformatf("pf_we_r%0d", r), vram_we, 0);
    repeat (3) begin @(posedge clk_25m); #1; end
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; row = 12'd0; colum = 12'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    repeat (2) @(posedge clk_25m);
    #1;
    check("rst_ack", cpu_ack, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_we", vram_we, 0);
    check("rst_addr", vram_addr, 0);
    check("rst_wdata", vram_wdata, 0);
    check("rst_pix", {pixel_r, pixel_g, pixel_b}, 0);
    @(posedge clk_25m); #1;
    rst = 1'b0;

`ifdef VRAM_CLEAR_EN
    cpu_txn("busy_rd", 1'b0, 16'hFF01, 8'h00, 4, 0, rd, cyc);
    check("busy_val", rd, 8'h81);
    check("busy_lat", cyc, 1);
    cpu_txn("clr_rd", 1'b0, 16'd31999, 8'h00, 40000, 0, rd, cyc);
    check("clr_rd_val", rd, 8'h00);
    check("clr_rd_late", (cyc >= 32000), 1);
    check("clr_last_addr", last_wa, 15'd31999);
`endif

    // Register reset values.
    cpu_txn("col_rst", 1'b0, 16'hFF00, 8'h00, 4, 0, rd, cyc);
    check("col_rst_val", rd, 8'h07);
    cpu_txn("ctl_rst", 1'b0, 16'hFF01, 8'h00, 4, 0, rd, cyc);
    check("ctl_rst_val", rd, 8'h01);

    // 1: write/read address 0.
    n0 = we_cnt;
    cpu_txn("wr0", 1'b1, 16'h0000, 8'hA5, 4, 0, rd, cyc);
    check("wr0_lat", cyc, 1);
    check("wr0_cnt", we_cnt - n0, 1);
    check("wr0_addr", last_wa, 0);
    check("wr0_data", last_wd, 8'hA5);
    cpu_txn("rd0", 1'b0, 16'h0000, 8'h00, 4, 0, rd, cyc);
    check("rd0_val", rd, 8'hA5);
    check("rd0_lat", cyc, 1);

    // 2: preload and display row 1.
    cpu_txn("wr80", 1'b1, 16'd80, 8'h80, 4, 0, rd, cyc);
    cpu_txn("wr81", 1'b1, 16'd81, 8'h01, 4, 0, rd, cyc);
    run_line(12'd0, 16, 1'b0, 15'd80, 3'b111, 3'b000, 1'b1, 1'b0);
    run_line(12'd1, 32, 1'b1, 15'd160, 3'b111, 3'b000, 1'b1, 1'b0);

    // 3: CPU read colliding with an in-line fetch slot.
    row = 12'd2; colum = 12'd1; pix_valid = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd81;
    #1;
    check("slot_disp_addr", vram_addr, 15'd161);
    check("slot_disp_ack", cpu_ack, 0);
    @(posedge clk_25m); #1; colum = 12'd2; #1;
    check("slot_grant_addr", vram_addr, 15'd81);
    check("slot_grant_ack", cpu_ack, 0);
    @(posedge clk_25m); #1; colum = 12'd3; #1;
    check("slot_ack", cpu_ack, 1);
    check("slot_rdata", cpu_rdata, 8'h01);
    @(posedge clk_25m); #1; colum = 12'd4; cpu_req = 1'b0; #1;
    check("slot_ack_pulse", cpu_ack, 0);
    // Last byte of a line: fetch at byte 78, none at byte 79.
    @(posedge clk_25m); #1; row = 12'd0; colum = 12'd625; #1;
    check("fetch_b78", vram_addr, 15'd79);
    @(posedge clk_25m); #1; colum = 12'd633; cpu_req = 1'b1; cpu_addr = 16'd80; #1;
    check("nofetch_b79_grant", vram_addr, 15'd80);
    @(posedge clk_25m); #1; colum = 12'd634; #1;
    check("b79_ack", cpu_ack, 1);
    check("b79_rdata", cpu_rdata, 8'h80);
    @(posedge clk_25m); #1; cpu_req = 1'b0; pix_valid = 1'b0;
    repeat (4) begin @(posedge clk_25m); #1; end

    // 4: colours and invert.
    cpu_txn("wr_col", 1'b1, 16'hFF00, 8'h42, 4, 0, rd, cyc);
    check("wr_col_lat", cyc, 1);
    cpu_txn("wr_ctl", 1'b1, 16'hFF01, 8'h03, 4, 0, rd, cyc);
    run_line(12'd0, 16, 1'b0, 15'd80, 3'b010, 3'b100, 1'b1, 1'b1);
    run_line(12'd1, 32, 1'b1, 15'd160, 3'b010, 3'b100, 1'b1, 1'b1);
    cpu_txn("rd_col", 1'b0, 16'hFF00, 8'h00, 4, 0, rd, cyc);
    check("rd_col_val", rd, 8'h42);
    cpu_txn("rd_ctl", 1'b0, 16'hFF01, 8'h00, 4, 0, rd, cyc);
    check("rd_ctl_val", rd, 8'h03);

    // 5: display disabled, unmapped accesses, held request.
    cpu_txn("wr_dis", 1'b1, 16'hFF01, 8'h00, 4, 0, rd, cyc);
    run_line(12'd0, 16, 1'b0, 15'd80, 3'b010, 3'b100, 1'b0, 1'b0);
    run_line(12'd1, 32, 1'b1, 15'd160, 3'b010, 3'b100, 1'b0, 1'b0);
    cpu_txn("rd_1234", 1'b0, 16'h1234, 8'h00, 4, 0, rd, cyc);
    check("rd_1234_val", rd, 8'h00);
    check("rd_1234_lat", cyc, 1);
    cpu_txn("rd_ff05", 1'b0, 16'hFF05, 8'h00, 4, 2, rd, cyc);
    check("rd_ff05_val", rd, 8'h00);
    check("rd_ff05_lat", cyc, 1);
    cpu_txn("wr_ff05", 1'b1, 16'hFF05, 8'h55, 4, 0, rd, cyc);
    cpu_txn("rd_col2", 1'b0, 16'hFF00, 8'h00, 4, 0, rd, cyc);
    check("rd_col2_val", rd, 8'h42);

    // Frame boundaries: last row wraps to row 0, rows past the frame do not prefetch.
    run_line(12'd399, 2, 1'b0, 15'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    run_line(12'd400, 2, 1'b0, 15'd0, 3'b000, 3'b000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
